button_event_decoder: RTL and testbench



---
 rtl/clock_ui_pkg.sv | 16 +
 rtl/btn_hold_counter.sv | 31 +++
 rtl/button_event_decoder.sv | 127 ++++++++++++
 tb/tb_button_event_decoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_ui_pkg.sv
// Shared definitions for the clock user-interface blocks: button FSM state
// encoding and the default press/repeat timing at a 100 MHz system clock.
package clock_ui_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } btn_state_t;

  // 1 s hold qualifies a long press; 200 ms auto-repeat period.
  localparam int unsigned BTN_LONG_CYCLES   = 100_000_000;
  localparam int unsigned BTN_REPEAT_CYCLES = 20_000_000;
  localparam int unsigned BTN_CNT_W         = 27;

endpackage

// File: rtl/btn_hold_counter.sv
// Hold-duration counter shared by the long-press and auto-repeat thresholds.
// The owner selects the terminal value; at_tc flags cnt == tc_val.
module btn_hold_counter #(
  parameter int unsigned CNT_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc_val,
  output logic             at_tc
);

  logic [CNT_W-1:0] cnt;

  // Count cycles while enabled; synchronous clear takes priority over enable.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_tc = (cnt == tc_val);

endmodule

// File: rtl/button_event_decoder.sv
// Turns debounced button activity into short_press, long_press and optional
// repeat_tick pulses for the time-set controller.
// Build option: define AUTO_REPEAT_EN to enable auto-repeat while held;
// without it repeat_tick is constant 0 and REPEAT_CYCLES is unused.
module button_event_decoder
  import clock_ui_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = BTN_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = BTN_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = BTN_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_state,
  input  logic pb_down,
  input  logic pb_up,
  output logic short_press,
  output logic long_press,
  output logic repeat_tick,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_t       state;
  logic             down_evt;
  logic             up_evt;
  logic             released;
  logic             cnt_clr;
  logic             cnt_en;
  logic             at_tc;
  logic [CNT_W-1:0] tc_val;

  // Simultaneous down and up pulses cancel out and count as no event.
  assign down_evt = pb_down & ~pb_up;
  assign up_evt   = pb_up & ~pb_down;
  // A dropped level without an up pulse is a missed release.
  assign released = up_evt | ~pb_state;
  assign tc_val   = (state == PRESSED) ? LONG_TC : REPEAT_TC;
  assign held     = (state != IDLE);

  btn_hold_counter #(.CNT_W(CNT_W)) u_hold_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .tc_val (tc_val),
    .at_tc  (at_tc)
  );

  // Counter control: restart on press and at each threshold, otherwise
  // advance while the button stays down.
  // NOTE: both outputs get a default first so no path leaves them unassigned
  // and no latch is inferred.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state)
      IDLE: cnt_clr = down_evt;
      PRESSED: begin
        if (!released) begin
          if (at_tc) cnt_clr = 1'b1;
          else       cnt_en  = 1'b1;
        end
      end
      LONG_HELD: begin
`ifdef AUTO_REPEAT_EN
        if (!released) begin
          if (at_tc) cnt_clr = 1'b1;
          else       cnt_en  = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

`ifdef AUTO_REPEAT_EN
  logic repeat_q;
  assign repeat_tick = repeat_q;
`else
  assign repeat_tick = 1'b0;
`endif

  // Press FSM with registered one-cycle event pulses; release beats threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      short_press <= 1'b0;
      long_press  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      repeat_q    <= 1'b0;
`endif
    end else begin
      short_press <= 1'b0;
      long_press  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      repeat_q    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (down_evt) state <= PRESSED;
        end
        PRESSED: begin
          if (up_evt) begin
            short_press <= 1'b1;
            state       <= IDLE;
          end else if (!pb_state) begin
            state <= IDLE;
          end else if (at_tc) begin
            long_press <= 1'b1;
            state      <= LONG_HELD;
          end
        end
        LONG_HELD: begin
          if (released) state <= IDLE;
`ifdef AUTO_REPEAT_EN
          else if (at_tc) repeat_q <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Randomised scoreboard bench for button_event_decoder (LONG=8, REPEAT=4).
// A press-level model predicts pulse cycles and the held level; a monitor
// on the falling edge matches DUT pulses against the expectation queue.
module tb_button_event_decoder;

  localparam int L = 8;
  localparam int R = 4;
  localparam int W = 8;

  typedef enum int {EV_SHORT, EV_LONG, EV_REPEAT} ev_kind_t;
  typedef struct {
    int       cyc;
    ev_kind_t kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic pb_state, pb_down, pb_up;
  logic short_press, long_press, repeat_tick, held;

  ev_t exp_q[$];
  bit  held_exp[int];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  button_event_decoder #(
    .LONG_CYCLES   (L),
    .REPEAT_CYCLES (R),
    .CNT_W         (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pb_state    (pb_state),
    .pb_down     (pb_down),
    .pb_up       (pb_up),
    .short_press (short_press),
    .long_press  (long_press),
    .repeat_tick (repeat_tick),
    .held        (held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: match each observed pulse against the scoreboard head.
  task automatic match_pulse(input ev_kind_t kind, input logic val);
    if (val !== 1'b0) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        check($sformatf("pulse_kind_%s", kind.name()), int'(kind), int'(exp_q[0].kind));
        void'(exp_q.pop_front());
      end else begin
        check($sformatf("unexpected_%s", kind.name()), {31'd0, val}, 32'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check($sformatf("missing_%s_at_%0d", exp_q[0].kind.name(), exp_q[0].cyc), 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    match_pulse(EV_SHORT, short_press);
    match_pulse(EV_LONG, long_press);
    match_pulse(EV_REPEAT, repeat_tick);
    if (held_exp.exists(cyc)) check("held", {31'd0, held}, {31'd0, held_exp[cyc]});
  end

  // Reference model: press starts (pb_down) in cycle p, ends in cycle p+k
  // by release or level drop; a reset in cycle p+rst_at cuts it short.
  task automatic model_press(input int p, input int k, input bit drop, input int rst_at);
    int cut;
    cut = (rst_at > 0) ? p + rst_at : p + k + 2;
    if (k <= L) begin
      if (!drop && p + k + 1 < cut) exp_q.push_back('{cyc: p + k + 1, kind: EV_SHORT});
    end else begin
      if (p + L + 1 < cut) exp_q.push_back('{cyc: p + L + 1, kind: EV_LONG});
`ifdef AUTO_REPEAT_EN
      for (int t = p + L + 1 + R; t <= p + k && t < cut; t += R)
        exp_q.push_back('{cyc: t, kind: EV_REPEAT});
`endif
    end
    held_exp[p] = 1'b0;
    if (rst_at > 0) begin
      for (int i = 1; i < rst_at; i++) held_exp[p + i] = 1'b1;
      held_exp[p + rst_at] = 1'b0;
    end else begin
      for (int i = 1; i <= k; i++) held_exp[p + i] = 1'b1;
      held_exp[p + k + 1] = 1'b0;
    end
  endtask

  task automatic do_press(input int k, input bit drop, input int extra_at, input int rst_at);
    int p;
    @(posedge clk); #1;
    p = cyc;
    model_press(p, k, drop, rst_at);
    pb_down  = 1'b1;
    pb_up    = 1'b0;
    pb_state = 1'b1;
    for (int i = 1; i <= k + 1; i++) begin
      @(posedge clk); #1;
      pb_down = (i == extra_at);
      pb_up   = 1'b0;
      if (i == k) begin
        pb_state = 1'b0;
        pb_up    = !drop;
      end else if (i > k) begin
        pb_state = 1'b0;
      end
      if (i == rst_at) begin
        #2;
        rst = 1'b1;
        #1;
        check("rst_short", {31'd0, short_press}, 32'd0);
        check("rst_long", {31'd0, long_press}, 32'd0);
        check("rst_repeat", {31'd0, repeat_tick}, 32'd0);
        check("rst_held", {31'd0, held}, 32'd0);
        pb_state = 1'b0;
        pb_down  = 1'b0;
        pb_up    = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
    end
  endtask

  // Idle cycles, optionally with stray up pulses or cancelling down+up pairs.
  task automatic idle_gap(input int n, input bit noise);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      pb_state = 1'b0;
      pb_down  = 1'b0;
      pb_up    = 1'b0;
      if (noise) begin
        case ($urandom_range(0, 3))
          0: pb_up = 1'b1;
          1: begin pb_down = 1'b1; pb_up = 1'b1; end
          default: ;
        endcase
      end
      held_exp[cyc]     = 1'b0;
      held_exp[cyc + 1] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, extra, rst_at;
    bit drop;
    rst = 1'b1; pb_state = 1'b0; pb_down = 1'b0; pb_up = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("init_short", {31'd0, short_press}, 32'd0);
    check("init_long", {31'd0, long_press}, 32'd0);
    check("init_repeat", {31'd0, repeat_tick}, 32'd0);
    check("init_held", {31'd0, held}, 32'd0);
    rst = 1'b0;
    idle_gap(50, 1'b0);

    // Directed cases.
    do_press(3, 1'b0, 0, 0);   idle_gap(3, 1'b0);  // short press
    do_press(8, 1'b0, 0, 0);   idle_gap(3, 1'b0);  // release on threshold
    do_press(9, 1'b0, 0, 0);   idle_gap(3, 1'b0);  // just long
    do_press(22, 1'b0, 0, 0);  idle_gap(3, 1'b0);  // long with repeats
    do_press(5, 1'b1, 0, 0);   idle_gap(3, 1'b0);  // missed release
    do_press(22, 1'b0, 4, 0);  idle_gap(3, 1'b0);  // stray pb_down ignored
    do_press(40, 1'b0, 0, 15); idle_gap(3, 1'b0);  // reset mid-hold

    // Randomised presses.
    repeat (40) begin
      k      = $urandom_range(1, L + 3 * R + 2);
      drop   = ($urandom_range(0, 3) == 0);
      extra  = (k >= 2 && $urandom_range(0, 2) == 0) ? $urandom_range(1, k - 1) : 0;
      rst_at = (k > 3 && $urandom_range(0, 9) == 0) ? $urandom_range(2, k - 1) : 0;
      do_press(k, drop, extra, rst_at);
      idle_gap($urandom_range(0, 4), 1'b1);
    end

    idle_gap(5, 1'b0);
    @(negedge clk); #1;
    while (exp_q.size() > 0) begin
      check($sformatf("unmatched_%s_at_%0d", exp_q[0].kind.name(), exp_q[0].cyc), 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
